// File: rtl/d_flip_flop.sv
// Positive-edge D flip-flop with complementary outputs and asynchronous active-high reset.
// WIDTH lets the same cell register a bus; qb is derived from the stored value, never stored separately.
module d_flip_flop #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    always_comb begin
        q_d = d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    // Complement comes off the single storage element so q/qb can never disagree.
    assign q  = q_q;
    assign qb = ~q_q;

endmodule

// File: tb/tb_d_flip_flop.sv
// Directed bench for d_flip_flop: 1-bit default instance plus a 4-bit instance with non-zero reset value.
module tb_d_flip_flop;

    logic       clk;
    logic       rst;
    logic       d;
    logic       q;
    logic       qb;
    logic [3:0] d4;
    logic [3:0] q4;
    logic [3:0] qb4;

    int n_chk;
    int n_err;

    d_flip_flop dut (
        .clk (clk),
        .rst (rst),
        .d   (d),
        .q   (q),
        .qb  (qb)
    );

    d_flip_flop #(.WIDTH(4), .RST_VAL(4'hA)) dut4 (
        .clk (clk),
        .rst (rst),
        .d   (d4),
        .q   (q4),
        .qb  (qb4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic chk_pair(input string tag, input logic exp_q);
        chk({tag, "_q"}, {3'b0, q}, {3'b0, exp_q});
        chk({tag, "_qb"}, {3'b0, qb}, {3'b0, ~exp_q});
    endtask

    initial begin
        logic       vec [5];
        logic [3:0] vec4 [5];
        vec  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vec4 = '{4'h5, 4'h0, 4'hF, 4'h3, 4'hC};
        n_chk = 0;
        n_err = 0;

        rst = 1'b1;
        d   = 1'b0;
        d4  = 4'h0;
        #1;
        // Reset must act before any clock edge has occurred.
        chk_pair("rst_async_start", 1'b0);
        chk("rst_val4", q4, 4'hA);
        chk("rst_val4_qb", qb4, 4'h5);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            d  = ~d;
            d4 = ~d4;
            @(posedge clk);
            #1;
            chk_pair("rst_hold", 1'b0);
            chk("rst_hold4", q4, 4'hA);
        end

        @(negedge clk);
        rst = 1'b0;
        d   = 1'b1;
        d4  = 4'h6;
        #1;
        chk_pair("release_pre_edge", 1'b0);
        chk("release_pre_edge4", q4, 4'hA);
        @(posedge clk);
        #1;
        chk_pair("release_capture", 1'b1);
        chk("release_capture4", q4, 4'h6);

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            d  = vec[i];
            d4 = vec4[i];
            @(posedge clk);
            #1;
            chk_pair("seq", vec[i]);
            chk("seq4", q4, vec4[i]);
            chk("seq4_qb", qb4, ~vec4[i]);
        end

        @(negedge clk);
        d = 1'b1;
        @(posedge clk);
        #1;
        chk_pair("glitch_setup", 1'b1);
        #2 d = 1'b0;
        #2 d = 1'b1;
        #1;
        chk_pair("glitch_mid", 1'b1);
        @(posedge clk);
        #1;
        chk_pair("glitch_after_edge", 1'b1);

        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk_pair("rst_mid_cycle", 1'b0);
        chk("rst_mid_cycle4", q4, 4'hA);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk_pair("rst_held_d1", 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_pair("rst_release_wait", 1'b0);
        @(posedge clk);
        #1;
        chk_pair("rst_release_capture", 1'b1);

        // Reset rising in the same timestep as the clock edge must win.
        @(posedge clk);
        rst = 1'b1;
        #1;
        chk_pair("rst_coincident", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_pair("post_coincident", 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/d_flip_flop.md
# d_flip_flop

Single-bit, positive-edge-triggered D flip-flop with complementary outputs and an asynchronous active-high reset. It is the basic storage element in the sequential-logic library and registers a data bit on every rising clock edge. Downstream logic can use both true (`q`) and inverted (`qb`) outputs. A `WIDTH` parameter allows the same block to register a bus, with the default one-bit behaviour as the primary use.

## Interface

Parameters:
- `WIDTH`, default 1: data width of `d`, `q` and `qb`.
- `RST_VAL`, default all-zeros: value loaded into `q` during reset.

Ports:
- `clk`  input  1  clock; all state changes except reset occur on its rising edge.
- `rst`  input  1  one clock; reset is asynchronous and active-high. While high, it forces `q = RST_VAL` regardless of `clk`.
- `d`  input  WIDTH  data to capture.
- `q`  output  WIDTH  registered data.
- `qb`  output  WIDTH  bitwise complement of `q`.

## Operation

- Reset asserted (`rst = 1`):
  - `q` takes `RST_VAL` (0) immediately, without waiting for a clock edge.
  - `qb` is `~RST_VAL` (1).
  - Clock edges and `d` are ignored for as long as `rst` stays high.
- Reset deasserted (`rst = 0`): on each rising edge of `clk`, `q <= d`.
- `qb` is always the combinational complement of the stored `q`, never an independent register. `qb == ~q` holds at all times, including during reset and at power-up once reset has been applied.
- Changes on `d` between rising edges have no effect on `q`.
- Falling edges of `clk` have no effect.
- There is no enable and no synchronous clear; the flop captures `d` on every edge outside reset.
- Before the first reset, `q`/`qb` are unknown (X in simulation). The system must apply reset before relying on the outputs.

## Timing

- Capture latency: `d` sampled at rising edge N appears on `q` immediately after edge N, with one clock-to-q delay and no extra pipeline stage.
- Reset assertion is asynchronous: `q` goes to `RST_VAL` within one propagation delay of `rst` rising, mid-cycle included.
- Reset deassertion:
  - Any rising edge at which `rst` is still high leaves `q = RST_VAL`.
  - The first rising edge with `rst` low captures `d`.
- Simultaneous `rst` rise and `clk` rise: reset wins, and `q = RST_VAL`.
- Reset asserted mid-operation (with `q = 1`): `q` drops to 0 and `qb` rises to 1 asynchronously. The held value is lost.
- The bench changes `d` and `rst` away from rising `clk` edges (e.g. on falling edges) to avoid race ambiguity. Reference clock period is 10 ns.

## Test plan

- Hold `rst = 1` for 10 cycles while toggling `d` 0/1 -> `q = 0`, `qb = 1` throughout; no clock edge changes `q`.
- Deassert reset with `rst = 0` and `d = 1` -> `q` stays 0 until the next rising edge, then `q = 1`, `qb = 0`.
- With `rst = 0`, drive `d = 1, 0, 1, 1, 0` on successive falling edges -> after each following rising edge `q` equals that value; `qb = ~q` at every sample.
- With `rst = 0` and `q = 1`, pulse `d` to 0 and back to 1 strictly between two rising edges -> `q` remains 1.
- With `q = 1`, assert `rst` 2 ns after a rising edge -> `q = 0`, `qb = 1` before the next edge. Keep `d = 1` while `rst` is held -> `q` stays 0. Release `rst` -> the next rising edge gives `q = 1`.
- Assert `rst` coincident with a rising edge while `d = 1` -> `q = 0` after that edge.
